// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: instruction classes, ALU op codes,
// controller states and shifter modes.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5,
        N_TYPE = 3'd6
    } instr_type_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    // Codes above this value have no operation assigned.
    localparam logic [3:0] ALU_OP_LAST = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_kind_e;

    localparam int SHAMT_W = 5;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    function automatic shift_kind_e shift_kind_of(input logic [3:0] op);
        shift_kind_e k;
        k = SH_SLL;
        if (op == ALU_SRL) k = SH_SRL;
        if (op == ALU_SRA) k = SH_SRA;
        return k;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative one-bit-per-cycle shifter. load captures the operand, count and
// shift kind; each step shifts by one and decrements the count. last flags
// the step that will bring the count to zero, and shift_out is the value the
// accumulator takes on that step, so the controller can latch it directly.
module alu_shifter
    import alu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  shift_kind_e        kind,
    input  logic [XLEN-1:0]    value,
    input  logic [SHAMT_W-1:0] amount,
    output logic [XLEN-1:0]    shift_out,
    output logic               last
);

    logic [XLEN-1:0]    acc;
    logic [SHAMT_W-1:0] count;
    shift_kind_e        kind_q;

    // One-bit shift of the accumulator with the fill chosen by the captured kind.
    always_comb begin
        shift_out = acc;
        case (kind_q)
            SH_SLL:  shift_out = {acc[XLEN-2:0], 1'b0};
            SH_SRL:  shift_out = {1'b0, acc[XLEN-1:1]};
            SH_SRA:  shift_out = {acc[XLEN-1], acc[XLEN-1:1]};
            default: shift_out = acc;
        endcase
    end

    assign last = (count == SHAMT_W'(1));

    // Accumulator and down-counter; a step with the count already at zero is inert.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            count  <= '0;
            kind_q <= SH_SLL;
        end else if (load) begin
            acc    <= value;
            count  <= amount;
            kind_q <= kind;
        end else if (step && (count != '0)) begin
            acc    <= shift_out;
            count  <= count - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops, iterative shifts.
// Results are held in registers until the next operation completes.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_op,
    input  logic            start,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy,
    output logic            done,
    output logic            illegal
);

    alu_state_e      state;
    logic [XLEN-1:0] calc;
    logic            op_illegal;
    logic            op_shift;
    logic            accept;
    logic            shift_load;
    logic            shift_step;
    logic            shift_last;
    logic [XLEN-1:0] shift_out;

    assign op_illegal = (alu_op > ALU_OP_LAST);
    assign op_shift   = is_shift_op(alu_op);
    // A start arriving mid-shift is dropped, not queued.
    assign accept     = start && (state != ST_SHIFT);
    assign shift_load = accept && op_shift;
    assign shift_step = (state == ST_SHIFT);

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

    // Single-cycle datapath for the non-shift ops; unused codes yield zero.
    always_comb begin
        calc = '0;
        case (alu_op)
            ALU_ADD:  calc = a + b;
            ALU_SUB:  calc = a - b;
            ALU_AND:  calc = a & b;
            ALU_OR:   calc = a | b;
            ALU_XOR:  calc = a ^ b;
            ALU_SLT:  calc = ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
            ALU_SLTU: calc = (a < b) ? XLEN'(1) : '0;
            default:  calc = '0;
        endcase
    end

    alu_shifter #(.XLEN(XLEN)) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (shift_load),
        .step      (shift_step),
        .kind      (shift_kind_of(alu_op)),
        .value     (a),
        .amount    (b[SHAMT_W-1:0]),
        .shift_out (shift_out),
        .last      (shift_last)
    );

    // Controller FSM and the registered result/zero/illegal outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            result  <= '0;
            zero    <= 1'b1;
            illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (!op_shift) begin
                            result  <= calc;
                            zero    <= (calc == '0);
                            illegal <= op_illegal;
                            state   <= ST_DONE;
                        end else if (b[SHAMT_W-1:0] == '0) begin
                            result  <= a;
                            zero    <= (a == '0);
                            illegal <= 1'b0;
                            state   <= ST_DONE;
                        end else begin
                            state   <= ST_SHIFT;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (shift_last) begin
                        result  <= shift_out;
                        zero    <= (shift_out == '0);
                        illegal <= 1'b0;
                        state   <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: operand/result width.
REQ-002 The block SHALL have port clk, input, 1: sole clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port a, input, XLEN: first operand from operand_build.
REQ-005 The block SHALL have port b, input, XLEN: second operand from operand_build; b[4:0] is the shift amount.
REQ-006 The block SHALL have port alu_op, input, 4: operation select.
REQ-007 The block SHALL have port start, input, 1: request; sampled on rising clk.
REQ-008 The block SHALL have port result, output, XLEN: registered result.
REQ-009 The block SHALL have port zero, output, 1: registered flag, high when result equals 0.
REQ-010 The block SHALL have port busy, output, 1: high while an iterative shift is in progress.
REQ-011 The block SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 The block SHALL have port illegal, output, 1: registered flag, high when the completed op code was unused.

Function
REQ-013 alu_op encoding SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA; codes 10-15 are illegal.
REQ-014 The state machine SHALL have states IDLE, SHIFT and DONE.
REQ-015 A start SHALL be accepted only in IDLE or DONE; start while in SHIFT SHALL be ignored, with no queuing.
REQ-016 On an accepted start, a, b and alu_op SHALL be captured on the same edge; later input changes SHALL have no effect on the operation in flight.
REQ-017 On acceptance of a non-shift op (0-6 or illegal), result, zero and illegal SHALL update on that edge, and the state SHALL go to DONE.
REQ-018 ADD/SUB SHALL wrap modulo 2^XLEN, with no carry output.
REQ-019 SLT/SLTU SHALL produce 32'd1 or 32'd0.
REQ-020 Illegal codes SHALL produce result 0, illegal=1 and zero=1.
REQ-021 On acceptance of a shift op, the accumulator SHALL load a and the counter SHALL load b[4:0].
REQ-022 For a shift op with a count of 0, result SHALL be set to a on that edge and the state SHALL go to DONE.
REQ-023 For a shift op with a nonzero count, the state SHALL go to SHIFT.
REQ-024 In SHIFT, each edge SHALL shift the accumulator by one bit and decrement the counter: SLL fills with 0, SRL fills with 0, SRA replicates the MSB.
REQ-025 On the SHIFT edge where the counter goes from 1 to 0, result and zero SHALL load the final value and the state SHALL go to DONE.
REQ-026 The latency from the start edge to done high SHALL be 1 cycle for non-shift ops and 1+n cycles for shifts by n (max 32).
REQ-027 done SHALL equal (state==DONE) and last exactly one cycle unless a new op immediately completes again.
REQ-028 From DONE, the state SHALL go to IDLE without start, or accept the new start directly, allowing back-to-back issue with zero bubble.
REQ-029 busy SHALL equal (state==SHIFT).
REQ-030 result, zero and illegal SHALL hold their last completed values until the next completion and SHALL not change during SHIFT.

Reset
REQ-031 While rst_n=0: state=IDLE, result=0, zero=1, illegal=0, busy=0, done=0, accumulator=0, counter=0.
REQ-032 Assertion of rst_n mid-SHIFT SHALL abort the operation immediately, with no done pulse.
REQ-033 The first start SHALL be honoured on the first rising clk edge after rst_n deasserts.

Structure
REQ-034 The alu_op codes and state encodings SHALL live in the shared package alongside the existing instr_type constants (R/I/S/B/U/J/N_TYPE).
REQ-035 The iterative shifter (accumulator, counter, fill logic) SHALL be one sub-module, alu_shifter, with load/step/last handshake; all other logic SHALL stay in alu_seq.

Verification
REQ-036 Scenario: ADD a=0xFFFFFFFF, b=1, start one cycle -> next cycle done=1, result=0, zero=1, busy never high.
REQ-037 Scenario: SLT a=0xFFFFFFFE, b=1 -> result=1; SLTU with the same operands -> result=0.
REQ-038 Scenario: SRA a=0x80000000, b=31 -> busy high 31 cycles, done 32 cycles after the start edge, result=0xFFFFFFFF; SRL with the same operands -> result=1.
REQ-039 Scenario: SLL a=0x1, b=0x20 (count 0) -> done after 1 cycle, result=0x1; start pulsed during SHIFT of a prior SLL by 8 -> ignored, only one done.
REQ-040 Scenario: back-to-back ADD 2+3 then XOR 0xF0^0xFF issued in the done cycle -> done high two consecutive cycles, results 5 then 0x0F.
REQ-041 Scenario: rst_n pulled low 3 cycles into an SRL by 20 -> busy=0 immediately, result=0, no done; alu_op=12 afterwards -> result=0, illegal=1.
